// File: rtl/wishbone_lsu.sv
// Load/store unit: turns one core byte/half/word request into a single Wishbone B4
// classic cycle, with lane steering, load extension and fault reporting.
module wishbone_lsu #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    output logic [1:0]  dbg_state_o
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d, cyc_q, cyc_d;
    logic          done_q, done_d, fault_q, fault_d, bad_q, bad_d;
    logic [1:0]    cause_q, cause_d, size_q, size_d, off_q, off_d;
    logic          uns_q, uns_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rty_q, rty_d;

    logic          misaligned;
    logic [3:0]    req_sel;
    logic [31:0]   req_dat, shifted, load_data;
    logic          finish;

    // Request decode: lane selects, replicated store data and alignment check.
    always_comb begin
        misaligned = 1'b0;
        req_sel    = 4'b0000;
        req_dat    = 32'h0;
        case (req_size_i)
            2'b00: begin
                req_sel = 4'b0001 << req_addr_i[1:0];
                req_dat = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr_i[0];
                req_sel    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                req_dat    = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                misaligned = (req_addr_i[1:0] != 2'b00);
                req_sel    = 4'b1111;
                req_dat    = req_wdata_i;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        shifted   = dat_i >> {off_q, 3'b000};
        load_data = shifted;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Handshake: a request transfers on a rising edge where req_valid_i and req_ready_o
    // are both 1; exactly one done_o pulse follows unless reset intervenes.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        tmo_d   = tmo_q;
        rty_d   = rty_q;
        bad_d   = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = 2'b00;
        rdata_d = 32'h0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bad_q) begin
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    cause_d = 2'b01;
                end else if (req_valid_i) begin
                    if (misaligned) begin
                        bad_d = 1'b1;
                    end else begin
                        adr_d   = {req_addr_i[31:2], 2'b00};
                        dat_d   = req_dat;
                        sel_d   = req_sel;
                        we_d    = req_we_i;
                        cyc_d   = 1'b1;
                        size_d  = req_size_i;
                        off_d   = req_addr_i[1:0];
                        uns_d   = req_unsigned_i;
                        tmo_d   = '0;
                        rty_d   = '0;
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                if (err_i) begin
                    finish  = 1'b1;
                    cause_d = 2'b10;
                end else if (ack_i) begin
                    finish = 1'b1;
                    if (!we_q) rdata_d = load_data;
                end else if (rty_i) begin
                    if (rty_q < RW'(MAX_RETRY)) begin
                        cyc_d   = 1'b0;
                        rty_d   = rty_q + RW'(1);
                        state_d = BACKOFF;
                    end else begin
                        finish  = 1'b1;
                        cause_d = 2'b11;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    finish  = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            BACKOFF: begin
                cyc_d   = 1'b1;
                tmo_d   = '0;
                state_d = BUS;
            end
            default: state_d = IDLE;
        endcase
        // Any terminal bus outcome releases the bus and parks its outputs at zero.
        if (finish) begin
            state_d = IDLE;
            done_d  = 1'b1;
            fault_d = (cause_d != 2'b00);
            cyc_d   = 1'b0;
            adr_d   = 32'h0;
            dat_d   = 32'h0;
            sel_d   = 4'b0000;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            tmo_q   <= '0;
            rty_q   <= '0;
            bad_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            tmo_q   <= tmo_d;
            rty_q   <= rty_d;
            bad_q   <= bad_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rdata_q <= rdata_d;
        end
    end

    // A rejected request holds off acceptance for one cycle so its done pulse is not overtaken.
    assign req_ready_o   = (state_q == IDLE) && !bad_q;
    assign done_o        = done_q;
    assign rdata_o       = rdata_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
    assign sel_o         = sel_q;
    assign we_o          = we_q;
    assign cyc_o         = cyc_q;
    assign stb_o         = cyc_q;
    assign dbg_state_o   = state_q;
endmodule
